// File: rtl/gpio_disp_shift_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_disp_shift_sched_if
//  Purpose  : Request/acknowledge bundle between the GPIO register block
//             (master) and the display shift scheduler (slave).
//  Signals  : led_req/led_data/led_ack  - LED chain update handshake
//             seg_req/seg_data/seg_ack  - 7-segment chain update handshake
//             busy                      - scheduler not idle
//  Revision : 1.0  initial release
// ============================================================================
interface gpio_disp_shift_sched_if;
  logic        led_req;
  logic [15:0] led_data;
  logic        led_ack;
  logic        seg_req;
  logic [63:0] seg_data;
  logic        seg_ack;
  logic        busy;

  modport master (
    output led_req, led_data, seg_req, seg_data,
    input  led_ack, seg_ack, busy
  );

  modport slave (
    input  led_req, led_data, seg_req, seg_data,
    output led_ack, seg_ack, busy
  );
endinterface
`default_nettype wire

// File: rtl/gpio_disp_shift_sched.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_disp_shift_sched
//  Purpose  : On-demand shift-out scheduler for the 16-bit LED chain and the
//             64-bit 7-segment chain. Round-robin arbitration between the two
//             requesters, one shared bit-serial engine, registered pins.
//  Ports    : HCLK, HRESETn (async, active-low)
//             bus        - request/ack handshake (slave modport)
//             led_clk/led_pen/led_clr_n/led_do - LED chain pins
//             seg_clk/seg_pen/seg_clr_n/seg_do - segment chain pins
//  Params   : CLK_DIV  - HCLK cycles per shift-clock half period and per
//                        latch strobe (1..255)
//             INIT_CYC - HCLK cycles clr_n is held low after reset
//  Revision : 1.0  initial release
// ============================================================================
module gpio_disp_shift_sched #(
  parameter int CLK_DIV  = 4,
  parameter int INIT_CYC = 8
) (
  input  wire                      HCLK,
  input  wire                      HRESETn,
  gpio_disp_shift_sched_if.slave   bus,
  output logic                     led_clk,
  output logic                     led_pen,
  output logic                     led_clr_n,
  output logic                     led_do,
  output logic                     seg_clk,
  output logic                     seg_pen,
  output logic                     seg_clr_n,
  output logic                     seg_do
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4
  } state_t;

  localparam logic       c_sel_led   = 1'b0;
  localparam logic       c_sel_seg   = 1'b1;
  localparam logic [7:0] c_div_last  = 8'(CLK_DIV - 1);
  localparam int         c_init_w    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [c_init_w-1:0] c_init_last = c_init_w'(INIT_CYC - 1);

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_div, w_div_nxt;
  logic [5:0]          r_bit, w_bit_nxt;
  // Data is held MSB-aligned so the outgoing bit is always bit 63,
  // whichever chain is selected.
  logic [63:0]         r_shift, w_shift_nxt;
  logic                r_sel, w_sel_nxt;
  logic                r_last, w_last_nxt;
  logic [c_init_w-1:0] r_init_cnt, w_init_nxt;
  logic                w_led_ack_nxt, w_seg_ack_nxt;
  logic                w_div_done;

  logic                w_clk_nxt, w_pen_nxt, w_do_nxt, w_run_nxt;
  logic                w_led_sel, w_seg_sel;

  assign w_div_done = (r_div == c_div_last);

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last;
    w_init_nxt    = r_init_cnt;
    w_led_ack_nxt = 1'b0;
    w_seg_ack_nxt = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == c_init_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_init_nxt = r_init_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        // On a tie the requester that was not served last wins.
        if (bus.led_req && (!bus.seg_req || (r_last == c_sel_seg))) begin
          w_sel_nxt     = c_sel_led;
          w_last_nxt    = c_sel_led;
          w_shift_nxt   = {bus.led_data, 48'd0};
          w_bit_nxt     = 6'd15;
          w_led_ack_nxt = 1'b1;
          w_div_nxt     = 8'd0;
          w_state_nxt   = ST_SHIFT_LO;
        end else if (bus.seg_req) begin
          w_sel_nxt     = c_sel_seg;
          w_last_nxt    = c_sel_seg;
          w_shift_nxt   = bus.seg_data;
          w_bit_nxt     = 6'd63;
          w_seg_ack_nxt = 1'b1;
          w_div_nxt     = 8'd0;
          w_state_nxt   = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (w_div_done) begin
          w_div_nxt   = 8'd0;
          w_state_nxt = ST_SHIFT_HI;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      ST_SHIFT_HI: begin
        if (w_div_done) begin
          w_div_nxt = 8'd0;
          if (r_bit == 6'd0) begin
            w_state_nxt = ST_LATCH;
          end else begin
            w_shift_nxt = {r_shift[62:0], 1'b0};
            w_bit_nxt   = r_bit - 6'd1;
            w_state_nxt = ST_SHIFT_LO;
          end
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      ST_LATCH: begin
        if (w_div_done) begin
          w_div_nxt   = 8'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Pin values are decoded from the next state so every pin comes straight
  // out of a flop and lines up with the state it belongs to.
  assign w_run_nxt = (w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI);
  assign w_clk_nxt = (w_state_nxt == ST_SHIFT_HI);
  assign w_pen_nxt = (w_state_nxt == ST_LATCH);
  assign w_do_nxt  = w_run_nxt & w_shift_nxt[63];
  assign w_led_sel = (w_sel_nxt == c_sel_led);
  assign w_seg_sel = (w_sel_nxt == c_sel_seg);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_INIT;
      r_div       <= 8'd0;
      r_bit       <= 6'd0;
      r_shift     <= 64'd0;
      r_sel       <= c_sel_led;
      r_last      <= c_sel_seg;
      r_init_cnt  <= '0;
      bus.led_ack <= 1'b0;
      bus.seg_ack <= 1'b0;
      bus.busy    <= 1'b1;
      led_clk     <= 1'b0;
      led_pen     <= 1'b0;
      led_do      <= 1'b0;
      led_clr_n   <= 1'b0;
      seg_clk     <= 1'b0;
      seg_pen     <= 1'b0;
      seg_do      <= 1'b0;
      seg_clr_n   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_sel       <= w_sel_nxt;
      r_last      <= w_last_nxt;
      r_init_cnt  <= w_init_nxt;
      bus.led_ack <= w_led_ack_nxt;
      bus.seg_ack <= w_seg_ack_nxt;
      bus.busy    <= (w_state_nxt != ST_IDLE);
      led_clk     <= w_clk_nxt & w_led_sel;
      led_pen     <= w_pen_nxt & w_led_sel;
      led_do      <= w_do_nxt  & w_led_sel;
      seg_clk     <= w_clk_nxt & w_seg_sel;
      seg_pen     <= w_pen_nxt & w_seg_sel;
      seg_do      <= w_do_nxt  & w_seg_sel;
      // INIT is only entered from reset, so clr_n stays high once released.
      led_clr_n   <= (w_state_nxt != ST_INIT);
      seg_clr_n   <= (w_state_nxt != ST_INIT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_disp_shift_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_disp_shift_sched
//  Purpose  : Self-checking bench for gpio_disp_shift_sched. Two instances:
//             u_dut4 (CLK_DIV=4) and u_dut1 (CLK_DIV=1), both INIT_CYC=8.
//             Channel index k = dut*2 + seg (dut 0 = u_dut4, 1 = u_dut1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpio_disp_shift_sched;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  gpio_disp_shift_sched_if bus4();
  gpio_disp_shift_sched_if bus1();

  logic led_clk4, led_pen4, led_clr_n4, led_do4, seg_clk4, seg_pen4, seg_clr_n4, seg_do4;
  logic led_clk1, led_pen1, led_clr_n1, led_do1, seg_clk1, seg_pen1, seg_clr_n1, seg_do1;

  gpio_disp_shift_sched #(.CLK_DIV(4), .INIT_CYC(8)) u_dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus4),
    .led_clk(led_clk4), .led_pen(led_pen4), .led_clr_n(led_clr_n4), .led_do(led_do4),
    .seg_clk(seg_clk4), .seg_pen(seg_pen4), .seg_clr_n(seg_clr_n4), .seg_do(seg_do4)
  );

  gpio_disp_shift_sched #(.CLK_DIV(1), .INIT_CYC(8)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1),
    .led_clk(led_clk1), .led_pen(led_pen1), .led_clr_n(led_clr_n1), .led_do(led_do1),
    .seg_clk(seg_clk1), .seg_pen(seg_pen1), .seg_clr_n(seg_clr_n1), .seg_do(seg_do1)
  );

  logic [3:0] p_clk, p_do, p_pen, p_ack;
  logic [1:0] p_busy;
  assign p_clk  = {seg_clk1, led_clk1, seg_clk4, led_clk4};
  assign p_do   = {seg_do1, led_do1, seg_do4, led_do4};
  assign p_pen  = {seg_pen1, led_pen1, seg_pen4, led_pen4};
  assign p_ack  = {bus1.seg_ack, bus1.led_ack, bus4.seg_ack, bus4.led_ack};
  assign p_busy = {bus1.busy, bus4.busy};

  // ---------------- chain monitors (free running, never cleared) ----------
  int        cyc = 0;
  int        rise_cnt[4];
  int        pen_pulse[4];
  int        pen_cyc[4];
  int        ack_cnt[4];
  bit [63:0] word[4];
  bit [3:0]  prev_clk, prev_pen;
  int        ack_cyc_q[$];
  int        ack_ch_q[$];

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    for (int k = 0; k < 4; k++) begin
      if (p_clk[k] && !prev_clk[k]) begin
        rise_cnt[k] <= rise_cnt[k] + 1;
        word[k]     <= {word[k][62:0], p_do[k]};
      end
      if (p_pen[k]) pen_cyc[k] <= pen_cyc[k] + 1;
      if (p_pen[k] && !prev_pen[k]) pen_pulse[k] <= pen_pulse[k] + 1;
      if (p_ack[k]) begin
        ack_cnt[k] <= ack_cnt[k] + 1;
        ack_cyc_q.push_back(cyc);
        ack_ch_q.push_back(k);
      end
    end
    prev_clk <= p_clk;
    prev_pen <= p_pen;
  end

  // ---------------- checking helpers -------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge HCLK);
    #1;
  endtask

  task automatic set_req(input int d, input bit s, input bit v, input logic [63:0] data);
    if (d == 0) begin
      if (s) begin bus4.seg_req = v; bus4.seg_data = data; end
      else   begin bus4.led_req = v; bus4.led_data = data[15:0]; end
    end else begin
      if (s) begin bus1.seg_req = v; bus1.seg_data = data; end
      else   begin bus1.led_req = v; bus1.led_data = data[15:0]; end
    end
  endtask

  task automatic wait_idle(input int d, input string name);
    int n = 0;
    while (p_busy[d] && n < 2000) begin step(); n++; end
    if (p_busy[d]) chk({name, "_idle_timeout"}, 1, 0);
  endtask

  // Reference arbitration state: last served chain per instance (1 = SEG).
  bit model_last[2];

  // ---------------- table-driven single transfers ------------------------
  typedef struct {
    int          dut;
    bit          seg;
    logic [63:0] data;
    int          exp_len;   // grant cycle + busy cycles
    int          exp_bits;
    int          exp_pen;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx, input vec_t v);
    int k = v.dut * 2 + int'(v.seg);
    int o = v.dut * 2 + int'(!v.seg);
    int r0 = rise_cnt[k], ro = rise_cnt[o];
    int p0 = pen_pulse[k], po = pen_pulse[o], pc0 = pen_cyc[k], a0 = ack_cnt[k];
    int n = 0;
    logic [63:0] mask = (v.exp_bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    string tag = $sformatf("vec%0d", idx);
    wait_idle(v.dut, tag);
    set_req(v.dut, v.seg, 1'b1, v.data);
    step();
    chk({tag, "_ack_pulse"}, p_ack[k], 1'b1);
    set_req(v.dut, v.seg, 1'b0, v.data);
    while (p_busy[v.dut] && n < 2000) begin n++; step(); end
    chk({tag, "_len"},       n + 1, v.exp_len);
    chk({tag, "_ack_cnt"},   ack_cnt[k] - a0, 1);
    chk({tag, "_rises"},     rise_cnt[k] - r0, v.exp_bits);
    chk({tag, "_word"},      word[k] & mask, v.data & mask);
    chk({tag, "_pen_pulse"}, pen_pulse[k] - p0, 1);
    chk({tag, "_pen_len"},   pen_cyc[k] - pc0, v.exp_pen);
    chk({tag, "_other_clk"}, rise_cnt[o] - ro, 0);
    chk({tag, "_other_pen"}, pen_pulse[o] - po, 0);
    model_last[v.dut] = v.seg;
  endtask

  // ---------------- randomized traffic on u_dut1 -------------------------
  task automatic rand_batch(input int it);
    int          mode = $urandom_range(0, 2);
    logic [63:0] ld = {48'd0, 16'($urandom)};
    logic [63:0] sd = {$urandom, $urandom};
    bit          order[$];
    bit          served_l = 0, served_s = 0;
    int          rl = rise_cnt[2], rs = rise_cnt[3], pl = pen_pulse[2], ps = pen_pulse[3];
    string       tag = $sformatf("rnd%0d", it);
    wait_idle(1, tag);
    if (mode == 0)      order.push_back(1'b0);
    else if (mode == 1) order.push_back(1'b1);
    else begin
      order.push_back(!model_last[1]);
      order.push_back(model_last[1]);
    end
    if (mode != 1) set_req(1, 1'b0, 1'b1, ld);
    if (mode != 0) set_req(1, 1'b1, 1'b1, sd);
    foreach (order[i]) begin
      int got = -1;
      int n = 0;
      while (got < 0 && n < 1000) begin
        step(); n++;
        if (bus1.led_ack) got = 0;
        else if (bus1.seg_ack) got = 1;
      end
      if (got < 0) begin
        chk({tag, "_ack_timeout"}, 1, 0);
        set_req(1, 1'b0, 1'b0, ld);
        set_req(1, 1'b1, 1'b0, sd);
        return;
      end
      chk({tag, "_rr_order"}, got, order[i]);
      set_req(1, got[0], 1'b0, got[0] ? sd : ld);
      model_last[1] = got[0];
      if (got == 0) served_l = 1; else served_s = 1;
    end
    wait_idle(1, tag);
    chk({tag, "_led_rises"}, rise_cnt[2] - rl, served_l ? 16 : 0);
    chk({tag, "_seg_rises"}, rise_cnt[3] - rs, served_s ? 64 : 0);
    chk({tag, "_led_pen"},   pen_pulse[2] - pl, served_l ? 1 : 0);
    chk({tag, "_seg_pen"},   pen_pulse[3] - ps, served_s ? 1 : 0);
    if (served_l) chk({tag, "_led_word"}, {48'd0, word[2][15:0]}, ld);
    if (served_s) chk({tag, "_seg_word"}, word[3], sd);
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    int n, rel_cyc, r0, p0, a0, rall;
    vecs[0] = '{0, 1'b0, 64'h0000_0000_0000_A5C3, 133, 16, 4};
    vecs[1] = '{0, 1'b1, 64'h0123_4567_89AB_CDEF, 517, 64, 4};
    vecs[2] = '{1, 1'b0, 64'h0000_0000_0000_FFFF,  34, 16, 1};
    vecs[3] = '{1, 1'b1, 64'hDEAD_BEEF_0000_FFFF, 130, 64, 1};
    vecs[4] = '{0, 1'b0, 64'h0000_0000_0000_0000, 133, 16, 4};
    vecs[5] = '{0, 1'b0, 64'h0000_0000_0000_8001, 133, 16, 4};
    vecs[6] = '{1, 1'b0, 64'h0000_0000_0000_1234,  34, 16, 1};

    HRESETn = 1'b0;
    bus1.led_req = 0; bus1.seg_req = 0; bus1.led_data = '0; bus1.seg_data = '0;
    // Both requests are already up while in reset (LED must win the first tie).
    bus4.led_req = 1; bus4.seg_req = 1;
    bus4.led_data = 16'h3C5A; bus4.seg_data = 64'hFEDC_BA98_7654_3210;
    repeat (3) step();

    // Reset values.
    chk("rst_pins4", {led_clk4, led_pen4, led_do4, seg_clk4, seg_pen4, seg_do4}, 6'b0);
    chk("rst_pins1", {led_clk1, led_pen1, led_do1, seg_clk1, seg_pen1, seg_do1}, 6'b0);
    chk("rst_clr_n", {led_clr_n4, seg_clr_n4, led_clr_n1, seg_clr_n1}, 4'b0);
    chk("rst_acks",  p_ack, 4'b0);
    chk("rst_busy",  p_busy, 2'b11);

    // INIT: clr_n low for INIT_CYC cycles after release, no shift activity.
    rall = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
    HRESETn = 1'b1;
    rel_cyc = cyc;
    n = 0;
    while (!led_clr_n4 && n < 50) begin n++; step(); end
    chk("init_clr_low_cycles", n, 8);
    chk("init_seg_clr_n", seg_clr_n4, 1'b1);
    chk("init_busy_fall", bus4.busy, 1'b0);
    chk("init_no_clk", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3] - rall, 0);
    chk("init_no_ack", ack_cyc_q.size(), 0);

    // Both held from reset: grants alternate LED, SEG, LED, SEG.
    n = 0;
    while (ack_cyc_q.size() < 4 && n < 3000) begin step(); n++; end
    bus4.led_req = 0; bus4.seg_req = 0;
    if (ack_cyc_q.size() < 4) chk("rr_ack_timeout", ack_cyc_q.size(), 4);
    else begin
      chk("rr_first_led", ack_ch_q[0], 0);
      chk("rr_then_seg",  ack_ch_q[1], 1);
      chk("rr_then_led",  ack_ch_q[2], 0);
      chk("rr_then_seg2", ack_ch_q[3], 1);
      chk("rr_first_ack_cycle", ack_cyc_q[0] - rel_cyc, 9);
      chk("rr_gap_led_seg", ack_cyc_q[1] - ack_cyc_q[0], 133);
      chk("rr_gap_seg_led", ack_cyc_q[2] - ack_cyc_q[1], 517);
      chk("rr_gap_led_seg2", ack_cyc_q[3] - ack_cyc_q[2], 133);
    end
    wait_idle(0, "rr");
    ack_cyc_q.delete(); ack_ch_q.delete();

    // Async reset after the 10th LED bit, request kept high throughout.
    r0 = rise_cnt[0]; p0 = pen_pulse[0]; a0 = ack_cnt[0];
    set_req(0, 1'b0, 1'b1, 64'h0000_0000_0000_C3A5);
    n = 0;
    while (rise_cnt[0] - r0 < 10 && n < 500) begin step(); n++; end
    chk("mid_ack_seen", ack_cnt[0] - a0, 1);
    chk("mid_ten_bits", rise_cnt[0] - r0, 10);
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_rst_pins", {led_clk4, led_pen4, led_do4, led_clr_n4, seg_clr_n4}, 5'b0);
    chk("mid_rst_busy", bus4.busy, 1'b1);
    chk("mid_rst_ack",  bus4.led_ack, 1'b0);
    step();
    chk("mid_no_pen", pen_pulse[0] - p0, 0);
    model_last[0] = 1'b1; model_last[1] = 1'b1;
    a0 = ack_cnt[0];
    HRESETn = 1'b1;
    r0 = rise_cnt[0];
    n = 0;
    while (!bus4.led_ack && n < 100) begin step(); n++; end
    chk("mid_fresh_ack_cycle", n, 9);
    set_req(0, 1'b0, 1'b0, 64'h0000_0000_0000_C3A5);
    model_last[0] = 1'b0;
    wait_idle(0, "mid");
    chk("mid_fresh_rises", rise_cnt[0] - r0, 16);
    chk("mid_fresh_word", {48'd0, word[0][15:0]}, 64'h0000_0000_0000_C3A5);
    chk("mid_fresh_pen", pen_pulse[0] - p0, 1);
    chk("mid_fresh_ack_cnt", ack_cnt[0] - a0, 1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    for (int it = 0; it < 30; it++) rand_batch(it);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/gpio_disp_shift_sched.md
Name: gpio_disp_shift_sched

Overview:
Shift-out scheduler for the two serial display chains on the Sword board: the 16-bit LED chain and the 64-bit 7-segment chain.
- Two requesters share one bit-serial shift engine.
- The GPIO register block raises led_req or seg_req with parallel data. This block arbitrates round-robin, latches the data and drives the chain pins (clk/pen/clr_n/do).
- Sits between the AHB GPIO slave and the board pins; it replaces free-running refresh with on-demand updates.

Parameters:
CLK_DIV, 4, HCLK cycles per half shift-clock period and latch-strobe width; legal range 1..255 (0 illegal).
INIT_CYC, 8, HCLK cycles clr_n is held low after reset release.

Ports:
HCLK  in  1  system clock
HRESETn  in  1  reset
led_req  in  1  LED update request; level, held until acked
led_data  in  16  LED pattern; bit 15 shifted first
led_ack  out  1  one-cycle pulse: led_data captured
seg_req  in  1  segment update request; level, held until acked
seg_data  in  64  segment pattern; bit 63 shifted first
seg_ack  out  1  one-cycle pulse: seg_data captured
busy  out  1  high while not in IDLE
led_clk, led_pen, led_clr_n, led_do  out  1 each  LED chain pins
seg_clk, seg_pen, seg_clr_n, seg_do  out  1 each  segment chain pins

Behaviour:
Interface: reset HRESETn, asynchronous, active-low; clock HCLK. All outputs are registered.

Reset values:
- All clk/pen/do = 0; both clr_n = 0.
- acks = 0; busy = 1.
- state = INIT; last_grant = SEG, so LED wins the first tie.

States:
- INIT
  - Both clr_n low for INIT_CYC cycles, then both clr_n go high and stay high until the next reset.
  - Next state IDLE.
  - Requests are ignored in INIT.
- IDLE
  - busy = 0.
  - At a posedge where any req = 1, grant:
    - Only one requesting: that one wins.
    - Both requesting: the one != last_grant wins.
  - On grant:
    - Capture data into the shift register (width 16 or 64).
    - bit counter = width-1.
    - last_grant updated.
    - Next state SHIFT_LO.
    - The winner's ack is high for exactly the following cycle (the first SHIFT_LO cycle).
- SHIFT_LO (CLK_DIV cycles)
  - Selected chain: clk = 0, do = current MSB.
- SHIFT_HI (CLK_DIV cycles)
  - Selected chain: clk = 1; do unchanged.
  - Exit: counter = 0 goes to LATCH. Otherwise shift left, decrement the counter, and return to SHIFT_LO.
- LATCH (CLK_DIV cycles)
  - Selected chain: clk = 0, do = 0, pen = 1.
  - Then pen = 0 and return to IDLE.

Unselected chain: clk, do, pen held 0 throughout.

Handshake:
- Data must be stable while req is high.
- The requester must deassert req the cycle after it sees ack, or else present new data. A req still high on return to IDLE is a new request.
- Requests are not sampled outside IDLE, so there is no preemption.

Timing:
- Transfer length from grant edge to IDLE = 1 + W·2·CLK_DIV + CLK_DIV cycles.
  - LED, CLK_DIV = 4: 1 + 128 + 4 = 133.
  - SEG, CLK_DIV = 4: 1 + 512 + 4 = 517.
- Minimum gap between back-to-back transfers: one IDLE cycle.

Boundary conditions:
- Both reqs rise in the same cycle: round-robin decides the winner. The loser is served immediately after, with no starvation.
- CLK_DIV = 1: clk toggles every HCLK; the structure is otherwise unchanged.
- Async reset mid-shift: pins go to reset values immediately. The transfer is abandoned with no ack pending, and the block re-enters INIT.

Test Plan:
1. Reset release, CLK_DIV = 4, INIT_CYC = 8: clr_n low 8 cycles after HRESETn rise then high; busy falls; no clk edges during INIT.
2. led_req with led_data = 16'hA5C3: led_ack pulses once, the cycle after the grant edge. 16 led_clk rising edges, and do sampled at each rise = A5C3 MSB-first. led_pen high 4 cycles after the last bit. seg pins stay 0. busy for 133 cycles.
3. seg_req with seg_data = 64'h0123_4567_89AB_CDEF: 64 rising edges carry the pattern MSB-first; one seg_pen pulse; total 517 cycles.
4. Both reqs asserted together from reset: LED served first, then SEG immediately after one IDLE cycle. Repeat with both held: grants alternate LED, SEG, LED...
5. HRESETn asserted after the 10th LED bit: outputs return to reset values asynchronously; no pen pulse; after release INIT reruns, and the still-held led_req gets a fresh ack and a full 16-bit transfer.
6. CLK_DIV = 1, LED transfer of 16'hFFFF: led_clk period 2 HCLK, do constant 1, total 1 + 32 + 1 = 34 cycles.
